// File: rtl/shift_left.sv
// shift_left: registered logical left barrel shifter with zero/lost status flags
module shift_left #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] s,
  input  logic               in_valid,
  output logic [WIDTH-1:0]   o,
  output logic               out_valid,
  output logic               zero,
  output logic               lost
);
  logic [SHAMT_W:0][WIDTH-1:0] st;
  logic [SHAMT_W:0]            dr;
  assign st[0] = in;
  assign dr[0] = 1'b0;
  // each stage also ORs in the bits it pushes past the MSB
  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign st[k+1] = s[k] ? {st[k][WIDTH-1-SH:0], {SH{1'b0}}} : st[k];
    assign dr[k+1] = dr[k] | (s[k] & (|st[k][WIDTH-1 -: SH]));
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      o         <= '0;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      lost      <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        o    <= st[SHAMT_W];
        zero <= ~|st[SHAMT_W];
        lost <= dr[SHAMT_W];
      end
    end
  end
endmodule

// File: tb/tb_shift_left.sv
// tb_shift_left: scoreboard bench for shift_left against a wide-shift reference model
module tb_shift_left;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic [31:0] in = '0;
  logic [4:0] s = '0;
  logic [31:0] o;
  logic out_valid, zero, lost;
  typedef struct packed {
    logic [31:0] o;
    logic        z;
    logic        l;
  } exp_t;
  exp_t q[$];
  exp_t held, e;
  int passed = 0;
  int total = 0;
  shift_left dut (
    .Clk(Clk), .Reset_n(Reset_n), .in(in), .s(s), .in_valid(in_valid),
    .o(o), .out_valid(out_valid), .zero(zero), .lost(lost)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [4:0] sh);
    logic [63:0] w;
    exp_t r;
    w = {32'd0, a} << sh;
    r.o = w[31:0];
    r.z = (w[31:0] == 32'd0);
    r.l = |w[63:32];
    return r;
  endfunction
  task automatic check_out(input string tag, input logic v, input exp_t x);
    chk({tag, " valid"}, 32'(out_valid), 32'(v));
    chk({tag, " o"}, o, x.o);
    chk({tag, " zero"}, 32'(zero), 32'(x.z));
    chk({tag, " lost"}, 32'(lost), 32'(x.l));
  endtask
  task automatic step(input string tag, input logic [31:0] a, input logic [4:0] sh, input logic v);
    @(negedge Clk);
    in = a;
    s = sh;
    in_valid = v;
    if (v) begin
      held = model(a, sh);
      q.push_back(held);
    end
    @(posedge Clk);
    #1;
    if (v && q.size() == 0) begin
      total++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      e = v ? q.pop_front() : held;
      check_out(tag, v, e);
    end
  endtask
  initial begin
    in = 32'hFFFF_FFFF;
    s = 5'd3;
    in_valid = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_out("reset_hold", 1'b0, '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    in_valid = 1'b0;
    held = '0;
    step("d5s1", 32'd5, 5'd1, 1'b1);
    step("d6s1", 32'd6, 5'd1, 1'b1);
    step("d3s2", 32'd3, 5'd2, 1'b1);
    step("d12s3", 32'd12, 5'd3, 1'b1);
    step("d0s0", 32'd0, 5'd0, 1'b1);
    step("b1s31", 32'h0000_0001, 5'd31, 1'b1);
    step("b80000001s1", 32'h8000_0001, 5'd1, 1'b1);
    step("bffs0", 32'hFFFF_FFFF, 5'd0, 1'b1);
    step("to_zero", 32'hF000_0000, 5'd4, 1'b1);
    step("d7s4", 32'd7, 5'd4, 1'b1);
    chk("d7s4 value", o, 32'd112);
    for (int i = 0; i < 4; i++) step("idle", $urandom, 5'($urandom_range(0, 31)), 1'b0);
    chk("idle o held", o, 32'd112);
    for (int sh = 0; sh < 32; sh++) begin
      step("rand", $urandom, 5'(sh), 1'b1);
      step("rand_hi", $urandom | 32'h8000_0000, 5'(sh), 1'b1);
    end
    step("zero_in", 32'd0, 5'd17, 1'b1);
    // reset asserted between edges with a pending operand
    @(negedge Clk);
    in = 32'h1234_5678;
    s = 5'd2;
    in_valid = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    check_out("async_reset", 1'b0, '0);
    @(posedge Clk);
    #1;
    check_out("reset_drop", 1'b0, '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    in_valid = 1'b0;
    held = '0;
    q.delete();
    step("post_reset", 32'h0000_00FF, 5'd8, 1'b1);
    step("post_idle", 32'hDEAD_BEEF, 5'd1, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
